voq_request_gen: RTL

- Per-input virtual-output-queue bookkeeping stage that sits directly upstream of the op-iSLIP grant selector.
- Keeps one occupancy counter per (priority row, output port) and drives the flattened P*N request vector into the selector.
- Consumes the selector's one-hot port/priority grant and runs the cell-transfer busy window. During that window it emits the busy and pointer-update strobes that the selector uses to advance its round-robin pointer.

---
 rtl/voq_request_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/voq_request_gen.sv
// voq_request_gen: per-(priority,port) VOQ occupancy counters driving the request vector and the cell-transfer busy window
module voq_request_gen #(
  parameter int N = 25,
  parameter int P = 8,
  parameter int NW = 5,
  parameter int PW = 3,
  parameter int CW = 8,
  parameter int CELL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_arr_valid,
  input  logic [NW-1:0]  i_arr_port,
  input  logic [PW-1:0]  i_arr_prio,
  output logic           o_arr_ready,
  output logic [P*N-1:0] o_port_req,
  input  logic [N-1:0]   i_port_grant,
  input  logic [P-1:0]   i_grant_priority,
  output logic           o_busy,
  output logic           o_random_robin,
  output logic           o_cell_valid,
  output logic [NW-1:0]  o_cell_port,
  output logic [PW-1:0]  o_cell_prio,
  output logic           o_grant_err
);
  typedef enum logic {IDLE, TRANSFER} state_t;
  localparam logic [7:0] BTOP = 8'(CELL_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic [CW-1:0] cnt_q [P*N];
  logic [CW-1:0] cnt_d [P*N];
  logic [P*N-1:0] req_q, req_d, fresh, gmask, arr_hit;
  logic [NW-1:0] port_q, port_d, gport;
  logic [PW-1:0] prio_q, prio_d, gprio;
  logic err_q, err_d, idle, gnone, gvalid, take, last, acc;
  always_comb begin
    o_arr_ready = 1'b0;
    gport = '0;
    gprio = '0;
    gmask = '0;
    arr_hit = '0;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < N; j++) begin
        arr_hit[i*N+j] = i_arr_prio == PW'(i) && i_arr_port == NW'(j);
        if (arr_hit[i*N+j]) o_arr_ready = cnt_q[i*N+j] != CMAX;
        gmask[i*N+j] = i_grant_priority[i] & i_port_grant[j];
      end
    end
    for (int j = 0; j < N; j++) if (i_port_grant[j]) gport = NW'(j);
    for (int i = 0; i < P; i++) if (i_grant_priority[i]) gprio = PW'(i);
    acc = i_arr_valid & o_arr_ready;
    idle = state_q == IDLE;
    last = state_q == TRANSFER && bcnt_q == '0;
    gnone = ~|i_port_grant & ~|i_grant_priority;
    gvalid = $onehot(i_port_grant) & $onehot(i_grant_priority) & |(gmask & req_q);
    take = idle & gvalid;
    for (int k = 0; k < P*N; k++) begin
      cnt_d[k] = cnt_q[k] + CW'(acc & arr_hit[k]) - CW'(take & gmask[k]);
      fresh[k] = cnt_d[k] != '0;
    end
    req_d = ((idle & ~gvalid) | last) ? fresh : req_q;
    state_d = take ? TRANSFER : last ? IDLE : state_q;
    bcnt_d = take ? BTOP : idle ? bcnt_q : bcnt_q - 8'd1;
    port_d = take ? gport : port_q;
    prio_d = take ? gprio : prio_q;
    err_d = idle & ~gnone & ~gvalid;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      cnt_q <= '{default: '0};
      req_q <= '0;
      port_q <= '0;
      prio_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      port_q <= port_d;
      prio_q <= prio_d;
      err_q <= err_d;
    end
  end
  assign o_port_req = req_q;
  assign o_busy = state_q == TRANSFER;
  assign o_random_robin = o_busy && bcnt_q == BTOP;
  assign o_cell_valid = o_random_robin;
  assign o_cell_port = port_q;
  assign o_cell_prio = prio_q;
  assign o_grant_err = err_q;
endmodule
